// File: rtl/memory_access_cycle_if.sv
// Data-memory request/acknowledge bus between the memory stage and the data memory.
// master: memory stage (drives the request, address, store data and byte enables)
// slave : data memory (drives the read word and the completion strobe)
interface memory_access_cycle_if;
  logic        DMemReq;
  logic        DMemWrite;
  logic [31:0] DMemAddr;
  logic [31:0] DMemWData;
  logic [3:0]  DMemByteEn;
  logic [31:0] DMemRData;
  logic        DMemAck;

  modport master (
    output DMemReq, DMemWrite, DMemAddr, DMemWData, DMemByteEn,
    input  DMemRData, DMemAck
  );

  modport slave (
    input  DMemReq, DMemWrite, DMemAddr, DMemWData, DMemByteEn,
    output DMemRData, DMemAck
  );
endinterface

// File: rtl/memory_access_cycle.sv
// Memory stage of the 5-stage RV32 pipeline: EX/MEM register, data-memory
// handshake, store lane alignment, load extension and upstream stall.
// Ports:
//   CLK, RESET          clock, synchronous active-high reset
//   *E inputs           results and control from the execution stage
//   dmem (master)       data-memory request/acknowledge bus
//   *M outputs          registered EX/MEM contents for forwarding/writeback
//   ReadDataM           extended load result (valid in the completing cycle)
//   StallMem            hold upstream stages and the EX/MEM register
//   MisalignedM         misaligned-access flag
// Optional feature: define MEM_MISALIGN_CHECK_EN to trap misaligned half/word
// accesses instead of silently aligning them.
module memory_access_cycle (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic [31:0]                  ALUOutE,
  input  logic [31:0]                  PCPlusImmE,
  input  logic [31:0]                  StoreDataE,
  input  logic [5:0]                   ALUSelectE,
  input  logic [4:0]                   WriteAddressE,
  input  logic                         RegWriteE,
  input  logic                         MemReadE,
  input  logic                         MemWriteE,
  input  logic                         JtypeE,
  memory_access_cycle_if.master        dmem,
  output logic [31:0]                  ALUOutM,
  output logic [31:0]                  PCPlusImmM,
  output logic [4:0]                   WriteAddressM,
  output logic                         RegWriteM,
  output logic                         MemReadM,
  output logic                         JtypeM,
  output logic [31:0]                  ReadDataM,
  output logic                         StallMem,
  output logic                         MisalignedM
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned REGW = 5;

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  typedef struct packed {
    logic [XLEN-1:0] alu_out;
    logic [XLEN-1:0] pc_plus_imm;
    logic [XLEN-1:0] store_data;
    logic [2:0]      funct3;
    logic [REGW-1:0] write_address;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            jtype;
  } entry_t;

  state_t          state_q, state_d;
  entry_t          entry_q, entry_d, entry_e;
  logic            stall_q, stall_d;
  logic            req_q, req_d;
  logic            write_q, write_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            advance;
  logic            mem_op;
  logic            misaligned_c;
  logic [1:0]      lane;
  logic [3:0]      be_c;
  logic [XLEN-1:0] wdata_c;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] load_ext;
  logic            unused_sel;

  // Only funct3 of the operation select matters in this stage
  assign unused_sel = ^ALUSelectE[5:3];

  assign entry_e = '{alu_out: ALUOutE, pc_plus_imm: PCPlusImmE, store_data: StoreDataE,
                     funct3: ALUSelectE[2:0], write_address: WriteAddressE,
                     reg_write: RegWriteE, mem_read: MemReadE, mem_write: MemWriteE,
                     jtype: JtypeE};

  assign mem_op  = entry_q.mem_read | entry_q.mem_write;
  assign lane    = entry_q.alu_out[1:0];
  assign advance = ~stall_q;

`ifdef MEM_MISALIGN_CHECK_EN
  // Half with odd address, or word (funct3[1] set) not on a word boundary
  assign misaligned_c = mem_op &&
                        ((entry_q.funct3[1:0] == 2'b01 && lane[0]) ||
                         (entry_q.funct3[1] && lane != 2'b00));
`else
  assign misaligned_c = 1'b0;
`endif

  // Store lane alignment; byte enables ignore sub-size address bits
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = entry_q.store_data;
    case (entry_q.funct3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << lane;
        wdata_c = {4{entry_q.store_data[7:0]}};
      end
      2'b01: begin
        be_c    = lane[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{entry_q.store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane select and extension of the returned word
  always_comb begin
    case (lane)
      2'd0:    byte_sel = dmem.DMemRData[7:0];
      2'd1:    byte_sel = dmem.DMemRData[15:8];
      2'd2:    byte_sel = dmem.DMemRData[23:16];
      default: byte_sel = dmem.DMemRData[31:24];
    endcase
    half_sel = lane[1] ? dmem.DMemRData[31:16] : dmem.DMemRData[15:0];
    case (entry_q.funct3)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_ext = {24'd0, byte_sel};
      3'b101:  load_ext = {16'd0, half_sel};
      default: load_ext = dmem.DMemRData;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mem_op) state_d = misaligned_c ? DONE : ACCESS;
      ACCESS:  if (dmem.DMemAck) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and the EX/MEM register
  always_comb begin
    entry_d = entry_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    if (advance) begin
      entry_d = entry_e;
      rdata_d = '0;
    end
    // Bus fields are latched once on entry to ACCESS so they stay stable until ack
    if (state_q == IDLE && state_d == ACCESS) begin
      write_d = entry_q.mem_write & ~entry_q.mem_read;
      addr_d  = {entry_q.alu_out[XLEN-1:2], 2'b00};
      wdata_d = wdata_c;
      be_d    = be_c;
    end
    // A trapped access must not write back
    if (state_q == IDLE && state_d == DONE) entry_d.reg_write = 1'b0;
    if (state_q == ACCESS && dmem.DMemAck && entry_q.mem_read) rdata_d = load_ext;
    req_d   = (state_d == ACCESS);
    stall_d = (state_d == ACCESS) ||
              (state_d == IDLE && (entry_d.mem_read || entry_d.mem_write));
  end

  // State and output registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      entry_q <= '0;
      stall_q <= 1'b0;
      req_q   <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      stall_q <= stall_d;
      req_q   <= req_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef MEM_MISALIGN_CHECK_EN
  logic mis_q;

  // One-cycle flag for the IDLE->DONE trap path
  always_ff @(posedge CLK) begin
    if (RESET) mis_q <= 1'b0;
    else       mis_q <= (state_q == IDLE) && (state_d == DONE);
  end

  assign MisalignedM = mis_q;
`else
  assign MisalignedM = 1'b0;
`endif

  assign dmem.DMemReq    = req_q;
  assign dmem.DMemWrite  = write_q;
  assign dmem.DMemAddr   = addr_q;
  assign dmem.DMemWData  = wdata_q;
  assign dmem.DMemByteEn = be_q;
  assign ALUOutM         = entry_q.alu_out;
  assign PCPlusImmM      = entry_q.pc_plus_imm;
  assign WriteAddressM   = entry_q.write_address;
  assign RegWriteM       = entry_q.reg_write;
  assign MemReadM        = entry_q.mem_read;
  assign JtypeM          = entry_q.jtype;
  assign ReadDataM       = rdata_q;
  assign StallMem        = stall_q;
endmodule

// File: tb/tb_memory_access_cycle.sv
// Scoreboard bench for memory_access_cycle: a byte-array reference memory
// predicts load results and bus requests; a responder plays the data memory
// and a monitor checks each stage completion against the expected queue.
module tb_memory_access_cycle;
`ifdef MEM_MISALIGN_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] alu_out;
    logic [31:0] pc;
    logic [31:0] rdata;
    logic [4:0]  wa;
    logic        rw;
    logic        mr;
    logic        jt;
    logic        mis;
    int          stalls;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        wr;
    int          delay;
  } req_t;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] ALUOutE, PCPlusImmE, StoreDataE;
  logic [5:0]  ALUSelectE;
  logic [4:0]  WriteAddressE;
  logic        RegWriteE, MemReadE, MemWriteE, JtypeE;
  logic [31:0] ALUOutM, PCPlusImmM, ReadDataM;
  logic [4:0]  WriteAddressM;
  logic        RegWriteM, MemReadM, JtypeM, StallMem, MisalignedM;

  int checks = 0;
  int errors = 0;

  exp_t exp_q[$];
  req_t req_q[$];
  logic [7:0]  ref_mem [0:1023];
  logic [31:0] dev_mem [0:255];

  memory_access_cycle_if mif();

  memory_access_cycle dut (
    .CLK(CLK), .RESET(RESET),
    .ALUOutE(ALUOutE), .PCPlusImmE(PCPlusImmE), .StoreDataE(StoreDataE),
    .ALUSelectE(ALUSelectE), .WriteAddressE(WriteAddressE),
    .RegWriteE(RegWriteE), .MemReadE(MemReadE), .MemWriteE(MemWriteE), .JtypeE(JtypeE),
    .dmem(mif),
    .ALUOutM(ALUOutM), .PCPlusImmM(PCPlusImmM), .WriteAddressM(WriteAddressM),
    .RegWriteM(RegWriteM), .MemReadM(MemReadM), .JtypeM(JtypeM),
    .ReadDataM(ReadDataM), .StallMem(StallMem), .MisalignedM(MisalignedM)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_word(input int waddr, input logic [31:0] w);
    for (int b = 0; b < 4; b++) ref_mem[(waddr & ~3) + b] = w[8*b +: 8];
    dev_mem[(waddr >> 2) & 255] = w;
  endtask

  task automatic zero_inputs();
    ALUOutE = '0; PCPlusImmE = '0; StoreDataE = '0; ALUSelectE = '0; WriteAddressE = '0;
    RegWriteE = 1'b0; MemReadE = 1'b0; MemWriteE = 1'b0; JtypeE = 1'b0;
  endtask

  // Present one operation at a negedge, predict its outcome, wait until it is taken.
  task automatic issue(input logic [31:0] alu, input logic [2:0] f3, input logic rd,
                       input logic wr, input logic [31:0] sd, input int dly);
    exp_t e;
    req_t r;
    int idx, hb, wb, size, n;
    logic mem, st, mis;
    logic [1:0] lo;
    logic [7:0] bv;
    logic [15:0] hv;
    logic [31:0] wv;
    ALUOutE = alu; PCPlusImmE = $urandom; StoreDataE = sd;
    ALUSelectE = {3'($urandom), f3}; WriteAddressE = 5'($urandom);
    RegWriteE = 1'($urandom); MemReadE = rd; MemWriteE = wr; JtypeE = 1'($urandom);

    mem  = rd | wr;
    st   = wr & ~rd;
    lo   = alu[1:0];
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    mis  = CHECK_EN && mem && ((size == 2 && lo[0]) || (size == 4 && lo != 2'b00));
    idx  = int'(alu[9:0]);
    hb   = idx & ~1;
    wb   = idx & ~3;
    bv   = ref_mem[idx];
    hv   = {ref_mem[hb+1], ref_mem[hb]};
    wv   = {ref_mem[wb+3], ref_mem[wb+2], ref_mem[wb+1], ref_mem[wb]};

    e.alu_out = alu; e.pc = PCPlusImmE; e.wa = WriteAddressE;
    e.rw = RegWriteE & ~mis; e.mr = rd; e.jt = JtypeE; e.mis = mis;
    e.stalls = !mem ? 0 : (mis ? 1 : 2 + dly);
    e.rdata = '0;
    if (rd && !mis) begin
      case (f3)
        3'b000:  e.rdata = {{24{bv[7]}}, bv};
        3'b001:  e.rdata = {{16{hv[15]}}, hv};
        3'b100:  e.rdata = {24'd0, bv};
        3'b101:  e.rdata = {16'd0, hv};
        default: e.rdata = wv;
      endcase
    end
    if (st && !mis) begin
      if (size == 1) ref_mem[idx] = sd[7:0];
      else if (size == 2) begin ref_mem[hb] = sd[7:0]; ref_mem[hb+1] = sd[15:8]; end
      else for (int b = 0; b < 4; b++) ref_mem[wb+b] = sd[8*b +: 8];
    end
    r.addr = {alu[31:2], 2'b00}; r.wr = st; r.delay = dly;
    if (size == 1) begin r.be = 4'(1 << lo); r.wdata = {4{sd[7:0]}}; end
    else if (size == 2) begin r.be = lo[1] ? 4'b1100 : 4'b0011; r.wdata = {2{sd[15:0]}}; end
    else begin r.be = 4'b1111; r.wdata = sd; end

    n = 0;
    while (StallMem && n < 200) begin @(negedge CLK); n++; end
    if (StallMem) begin
      checks++; errors++;
      $display("FAIL issue_timeout: StallMem still 1 after %0d cycles, required 0", n);
      return;
    end
    @(posedge CLK);
    exp_q.push_back(e);
    if (mem && !mis) req_q.push_back(r);
    @(negedge CLK);
  endtask

  // Data-memory model: checks each request cycle and acks after the planned delay
  initial begin : responder
    bit active;
    int wait_left;
    int widx;
    req_t cur;
    active = 0; wait_left = 0;
    mif.DMemAck = 1'b0; mif.DMemRData = '0;
    forever begin
      @(negedge CLK);
      mif.DMemAck = 1'b0;
      mif.DMemRData = $urandom;
      if (RESET || !mif.DMemReq) begin
        active = 0;
      end else begin
        if (!active) begin
          if (req_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_req: DMemReq=1 addr 0x%08h, required no request", mif.DMemAddr);
            mif.DMemAck = 1'b1;
            continue;
          end
          cur = req_q[0];
          active = 1;
          wait_left = cur.delay;
        end
        chk("DMemAddr", mif.DMemAddr, cur.addr);
        chk("DMemWrite", 32'(mif.DMemWrite), 32'(cur.wr));
        if (cur.wr) begin
          chk("DMemByteEn", 32'(mif.DMemByteEn), 32'(cur.be));
          chk("DMemWData", mif.DMemWData, cur.wdata);
        end
        if (wait_left == 0) begin
          mif.DMemAck = 1'b1;
          widx = int'(mif.DMemAddr[9:2]);
          if (mif.DMemWrite) begin
            for (int b = 0; b < 4; b++)
              if (mif.DMemByteEn[b]) dev_mem[widx][8*b +: 8] = mif.DMemWData[8*b +: 8];
          end else begin
            mif.DMemRData = dev_mem[widx];
          end
          void'(req_q.pop_front());
          active = 0;
        end else begin
          wait_left--;
        end
      end
    end
  end

  // Completion monitor: an entry retires on the first non-stalled cycle after entry
  initial begin : monitor
    int stalls;
    exp_t e;
    stalls = 0;
    forever begin
      @(negedge CLK);
      if (RESET) stalls = 0;
      else if (StallMem) stalls++;
      else begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("ALUOutM", ALUOutM, e.alu_out);
          chk("PCPlusImmM", PCPlusImmM, e.pc);
          chk("WriteAddressM", 32'(WriteAddressM), 32'(e.wa));
          chk("RegWriteM", 32'(RegWriteM), 32'(e.rw));
          chk("MemReadM", 32'(MemReadM), 32'(e.mr));
          chk("JtypeM", 32'(JtypeM), 32'(e.jt));
          chk("ReadDataM", ReadDataM, e.rdata);
          chk("MisalignedM", 32'(MisalignedM), 32'(e.mis));
          chk("stall_cycles", 32'(stalls), 32'(e.stalls));
        end
        stalls = 0;
      end
    end
  end

  initial begin : main
    logic [2:0] ld_codes [5];
    logic [2:0] f3;
    logic [31:0] a;
    int kind, dly, n;
    ld_codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'($urandom);
    for (int w = 0; w < 256; w++)
      dev_mem[w] = {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};

    RESET = 1'b1;
    zero_inputs();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("reset_DMemReq", 32'(mif.DMemReq), 32'd0);
    chk("reset_StallMem", 32'(StallMem), 32'd0);
    chk("reset_ALUOutM", ALUOutM, 32'd0);
    chk("reset_ReadDataM", ReadDataM, 32'd0);
    chk("reset_RegWriteM", 32'(RegWriteM), 32'd0);
    chk("reset_MisalignedM", 32'(MisalignedM), 32'd0);
    RESET = 1'b0;

    issue(32'h0000_1234, 3'b000, 1'b0, 1'b0, 32'h0, 0);           // ALU op
    set_word(32'h100, 32'h80FF_0000);
    issue(32'h0000_0103, 3'b000, 1'b1, 1'b0, $urandom, 0);        // LB
    issue(32'h0000_0202, 3'b001, 1'b0, 1'b1, 32'hDEAD_BEEF, 0);   // SH
    issue(32'h0000_0300, 3'b010, 1'b1, 1'b0, $urandom, 3);        // LW, 3 wait cycles

    // Reset in the middle of a long access
    issue(32'h0000_0040, 3'b010, 1'b1, 1'b0, $urandom, 10);
    n = 0;
    while (!mif.DMemReq && n < 20) begin @(negedge CLK); n++; end
    chk("req_before_reset", 32'(mif.DMemReq), 32'd1);
    RESET = 1'b1;
    zero_inputs();
    @(posedge CLK);
    @(negedge CLK);
    exp_q.delete();
    req_q.delete();
    chk("rst_mid_DMemReq", 32'(mif.DMemReq), 32'd0);
    chk("rst_mid_DMemAddr", mif.DMemAddr, 32'd0);
    chk("rst_mid_DMemWData", mif.DMemWData, 32'd0);
    chk("rst_mid_DMemByteEn", 32'(mif.DMemByteEn), 32'd0);
    chk("rst_mid_StallMem", 32'(StallMem), 32'd0);
    chk("rst_mid_ALUOutM", ALUOutM, 32'd0);
    chk("rst_mid_PCPlusImmM", PCPlusImmM, 32'd0);
    chk("rst_mid_MemReadM", 32'(MemReadM), 32'd0);
    chk("rst_mid_ReadDataM", ReadDataM, 32'd0);
    RESET = 1'b0;
    issue(32'h0000_0040, 3'b010, 1'b1, 1'b0, $urandom, 1);        // LW after reset

    issue(32'h0000_0101, 3'b010, 1'b1, 1'b0, $urandom, 0);        // misaligned LW

    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 3);
      a    = 32'($urandom_range(0, 1023));
      dly  = $urandom_range(0, 3);
      case (kind)
        0: issue($urandom, 3'($urandom), 1'b0, 1'b0, $urandom, 0);
        1: issue(a, ld_codes[$urandom_range(0, 4)], 1'b1, 1'b0, $urandom, dly);
        2: begin
          f3 = 3'($urandom_range(0, 2));
          issue(a, f3, 1'b0, 1'b1, $urandom, dly);
        end
        default: issue(a, ld_codes[$urandom_range(0, 4)], 1'b1, 1'b1, $urandom, dly);
      endcase
    end
    zero_inputs();

    n = 0;
    while ((exp_q.size() > 0 || req_q.size() > 0) && n < 1000) begin @(negedge CLK); n++; end
    chk("drain_exp_pending", 32'(exp_q.size()), 32'd0);
    chk("drain_req_pending", 32'(req_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/memory_access_cycle.md
# memory_access_cycle

Memory-stage block of the 5-stage RV32 pipeline: consumes the execution stage's results (ALU address, store data, control), holds them in the EX/MEM pipeline register, and runs the data-memory request/acknowledge handshake. It aligns store data into byte lanes and generates byte enables. It sign- or zero-extends load data. It stalls the upstream pipeline while an access is outstanding.

## Interface
Parameters:
- None.

Ports:
- CLK  in  1  pipeline clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- ALUOutE  in  32  ALU result from execution stage; effective address for memory ops.
- PCPlusImmE  in  32  branch/jump target from execution stage.
- StoreDataE  in  32  right-aligned store data from execution stage.
- ALUSelectE  in  6  operation select; bits [2:0] are funct3 for loads/stores.
- WriteAddressE  in  5  destination register.
- RegWriteE, MemReadE, MemWriteE, JtypeE  in  1 each  control from execution stage.
- DMemReq  out  1  data-memory request valid.
- DMemWrite  out  1  1 = store, 0 = load; valid while DMemReq = 1.
- DMemAddr  out  32  word-aligned address (bits [1:0] = 0).
- DMemWData  out  32  lane-aligned store data.
- DMemByteEn  out  4  byte lane enables.
- DMemRData  in  32  read word; sampled only in the cycle DMemAck = 1.
- DMemAck  in  1  memory completion strobe.
- ALUOutM, PCPlusImmM  out  32 each  registered values, used for forwarding and writeback.
- WriteAddressM  out  5  registered destination register.
- RegWriteM, MemReadM, JtypeM  out  1 each  registered control.
- ReadDataM  out  32  extended load result.
- StallMem  out  1  1 = hold the IF/ID/EX stages and this block's EX/MEM register.
- MisalignedM  out  1  misaligned-access flag. Always present; driven 0 when the feature is compiled out.

## Operation
- EX/MEM register:
  - Captures all *E inputs on a rising edge when StallMem = 0.
  - Holds its contents when StallMem = 1.
  - RESET clears every field to 0, which is a bubble.
- A memory op is a register entry with MemReadM or MemWriteM set. If both are set, it is treated as a load.
- FSM states:
  - IDLE:
    - No memory op in the register: StallMem = 0.
    - Memory op present: StallMem = 1, next state ACCESS (or DONE on a misaligned access when the check is enabled).
  - ACCESS:
    - DMemReq = 1 and StallMem = 1.
    - DMemAddr, DMemWrite, DMemWData and DMemByteEn stay stable until acknowledged.
    - When DMemAck = 1: DMemRData is captured into the load buffer and the next state is DONE.
    - When DMemAck = 0: the FSM stays in ACCESS, with no timeout.
  - DONE: StallMem = 0, ReadDataM is valid, the register advances, and the next state is IDLE.
- Byte lanes, using a = ALUOutM[1:0]:
  - Byte (funct3 x00): ByteEn = 0001 << a; WData = {4{StoreData[7:0]}}.
  - Half (funct3 x01): ByteEn = 0011 << (a[1]*2); WData = {2{StoreData[15:0]}}.
  - Word (funct3 010): ByteEn = 1111; WData = StoreData.
- Load extension from the load buffer at lane a:
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend half.
  - 010 LW: full word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
  - Other codes: ReadDataM = full word.
- ReadDataM = 0 whenever MemReadM = 0.
- RESET in any state:
  - The FSM returns to IDLE and DMemReq deasserts the same edge.
  - An outstanding request is abandoned; the memory must tolerate this.
  - All outputs become 0.

## Timing
- Reset value of all outputs is 0; FSM reset state is IDLE.
- Non-memory op: 1 cycle in this stage with no stall.
- Memory op with DMemAck in the first ACCESS cycle: 3 cycles (IDLE, ACCESS, DONE) and 2 stall cycles.
- Each additional wait cycle adds 1.
- DMemReq is registered: it rises on the edge entering ACCESS and falls on the edge leaving ACCESS.
- DMemAck is ignored outside ACCESS.
- ALUOutM and RegWriteM are valid every cycle for the forwarding unit, including during stalls, because the register holds.
- A memory op that directly follows a memory op enters IDLE on the DONE edge and begins its own sequence. Back-to-back accesses never overlap.

## Configuration
- MEM_MISALIGN_CHECK_EN defined:
  - A half access with a[0] = 1, or a word access with a != 0, issues no DMemReq.
  - The FSM goes IDLE → DONE.
  - In DONE: MisalignedM = 1 for 1 cycle, ReadDataM = 0, and RegWriteM is forced to 0.
- Undefined:
  - Low address bits that break natural alignment are ignored: a[0] is cleared for halves and a is cleared for words.
  - MisalignedM is tied to 0.

## Test plan
- ALU op (MemRead = MemWrite = 0), ALUOutE = 0x1234 → ALUOutM = 0x1234 one edge later; StallMem never asserts.
- LB at address 0x103 with DMemRData = 0x80FF_0000 and ack in the first ACCESS cycle → DMemAddr = 0x100, StallMem high for 2 cycles, ReadDataM = 0xFFFF_FF80.
- SH at address 0x202 with StoreData = 0xDEAD_BEEF → DMemByteEn = 1100, DMemWData = 0xBEEF_BEEF, DMemWrite = 1.
- LW with ack delayed 3 cycles → DMemReq and address held stable for 4 ACCESS cycles, StallMem high for 5 cycles, ReadDataM = DMemRData.
- RESET asserted during ACCESS → DMemReq = 0 and all outputs = 0 after that edge; a later LW completes normally.
- With the macro defined, LW at 0x101 → no DMemReq, MisalignedM = 1 for 1 cycle, RegWriteM = 0. Without the macro, the same access uses DMemAddr = 0x100.
